// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard/stall unit.
//   state_e   : stall FSM encoding (RUN = normal issue, HOLD = second stall cycle pending)
//   REG_ZERO  : architectural zero register, never a hazard source
//   reg_match : true when a producer's destination feeds an operand the ID instruction reads
package hazard_stall_unit_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A write to r0 is discarded by the register file, so it can never create a dependency.
  // rs == rt with both matching collapses into a single boolean, i.e. one hazard.
  function automatic logic reg_match(input logic [4:0] rd, input logic wr_en,
                                     input logic [4:0] rs, input logic uses_rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return wr_en && (rd != REG_ZERO) && ((uses_rs && (rd == rs)) || (uses_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard bus between the pipeline and the hazard/stall unit.
//   master : pipeline side; drives operand/producer info, receives stall/flush controls
//   slave  : hazard unit side; the reverse
interface hazard_stall_unit_if;

  logic [4:0] rs_IF_ID;
  logic [4:0] rt_IF_ID;
  logic       UsesRs_ID;
  logic       UsesRt_ID;
  logic       Branch_ID;
  logic       BranchTaken_ID;
  logic [4:0] rd_ID_EX;
  logic       RegWrite_ID_EX;
  logic       MemRead_ID_EX;
  logic [4:0] rd_EX_MEM;
  logic       MemRead_EX_MEM;
  logic       PCWrite;
  logic       IF_ID_Write;
  logic       ID_EX_Bubble;
  logic       IF_ID_Flush;

  modport master (
    output rs_IF_ID, rt_IF_ID, UsesRs_ID, UsesRt_ID, Branch_ID, BranchTaken_ID,
    output rd_ID_EX, RegWrite_ID_EX, MemRead_ID_EX, rd_EX_MEM, MemRead_EX_MEM,
    input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush
  );

  modport slave (
    input  rs_IF_ID, rt_IF_ID, UsesRs_ID, UsesRt_ID, Branch_ID, BranchTaken_ID,
    input  rd_ID_EX, RegWrite_ID_EX, MemRead_ID_EX, rd_EX_MEM, MemRead_EX_MEM,
    output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush
  );

endinterface

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter for performance statistics.
//   Clk   : clock, rising edge
//   Reset : synchronous active-high clear
//   Inc   : count this cycle
//   Count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count <= '0;
    end else if (Inc && (Count != {W{1'b1}})) begin
      Count <= Count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector for dependencies forwarding cannot resolve: load-use, and
// operands of a branch that compares in ID. Generates PC / IF_ID enables, the ID_EX
// bubble and the IF_ID flush, plus saturating stall/flush counters.
//   Clk, Reset : clock and synchronous active-high reset
//   hz         : hazard bus (slave side)
//   StallCount : saturating count of stall cycles
//   FlushCount : saturating count of flush cycles
module hazard_stall_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  hazard_stall_unit_if.slave hz,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   FlushCount
);

  import hazard_stall_unit_pkg::*;

  state_e state_q;
  logic   match_ex;
  logic   match_mem;
  logic   need_two;
  logic   need_one;
  logic   stall;
  logic   flush;

  always_comb begin
    match_ex  = reg_match(hz.rd_ID_EX, hz.RegWrite_ID_EX, hz.rs_IF_ID, hz.UsesRs_ID,
                          hz.rt_IF_ID, hz.UsesRt_ID);
    match_mem = reg_match(hz.rd_EX_MEM, hz.MemRead_EX_MEM, hz.rs_IF_ID, hz.UsesRs_ID,
                          hz.rt_IF_ID, hz.UsesRt_ID);

    // Branch on a value still being loaded in EX: one cycle to reach MEM, one more for
    // the load data to be forwardable into ID.
    need_two = hz.Branch_ID && hz.MemRead_ID_EX && match_ex;
    need_one = (hz.MemRead_ID_EX && match_ex && !hz.Branch_ID) ||
               (hz.Branch_ID && !hz.MemRead_ID_EX && match_ex) ||
               (hz.Branch_ID && match_mem && !match_ex);

    // HOLD stalls regardless of inputs; reset masks everything.
    stall = !Reset && ((state_q == HOLD) || need_two || need_one);
    // Branch outcome is only trusted in a non-stall cycle.
    flush = !Reset && !stall && hz.BranchTaken_ID;

    hz.PCWrite      = !stall;
    hz.IF_ID_Write  = !stall;
    hz.ID_EX_Bubble = stall;
    hz.IF_ID_Flush  = flush;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
    end else if ((state_q == RUN) && need_two) begin
      state_q <= HOLD;
    end else begin
      state_q <= RUN;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (stall),
    .Count (StallCount)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (flush),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int NV = 28;

  logic        Clk;
  logic        Reset;
  logic        Reset_s;
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
  logic [3:0]  StallCount_s;
  logic [3:0]  FlushCount_s;

  hazard_stall_unit_if hz ();
  hazard_stall_unit_if hzs ();

  hazard_stall_unit #(
    .CNT_W (16)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .hz         (hz),
    .StallCount (StallCount),
    .FlushCount (FlushCount)
  );

  hazard_stall_unit #(
    .CNT_W (4)
  ) dut_small (
    .Clk        (Clk),
    .Reset      (Reset_s),
    .hz         (hzs),
    .StallCount (StallCount_s),
    .FlushCount (FlushCount_s)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, br, bt;
    logic [4:0] rd_ex;
    logic       rw_ex, mr_ex;
    logic [4:0] rd_mem;
    logic       mr_mem;
    logic       e_stall, e_flush;
  } vec_t;

  typedef struct {
    int   idx;
    logic pcw, ifw, bub, fl;
    int   sc, fc;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   sat_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_sc = 0;
  int   m_fc = 0;

  function automatic vec_t mk(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic br, input logic bt,
                              input logic [4:0] rd_ex, input logic rw_ex, input logic mr_ex,
                              input logic [4:0] rd_mem, input logic mr_mem,
                              input logic e_stall, input logic e_flush);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.br = br; v.bt = bt;
    v.rd_ex = rd_ex; v.rw_ex = rw_ex; v.mr_ex = mr_ex; v.rd_mem = rd_mem; v.mr_mem = mr_mem;
    v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    Reset             = v.rst;
    hz.rs_IF_ID       = v.rs;
    hz.rt_IF_ID       = v.rt;
    hz.UsesRs_ID      = v.urs;
    hz.UsesRt_ID      = v.urt;
    hz.Branch_ID      = v.br;
    hz.BranchTaken_ID = v.bt;
    hz.rd_ID_EX       = v.rd_ex;
    hz.RegWrite_ID_EX = v.rw_ex;
    hz.MemRead_ID_EX  = v.mr_ex;
    hz.rd_EX_MEM      = v.rd_mem;
    hz.MemRead_EX_MEM = v.mr_mem;
  endtask

  task automatic apply_small(input logic [4:0] rs, input logic [4:0] rd, input logic ld);
    hzs.rs_IF_ID       = rs;
    hzs.rt_IF_ID       = 5'd0;
    hzs.UsesRs_ID      = 1'b1;
    hzs.UsesRt_ID      = 1'b0;
    hzs.Branch_ID      = 1'b0;
    hzs.BranchTaken_ID = 1'b0;
    hzs.rd_ID_EX       = rd;
    hzs.RegWrite_ID_EX = ld;
    hzs.MemRead_ID_EX  = ld;
    hzs.rd_EX_MEM      = 5'd0;
    hzs.MemRead_EX_MEM = 1'b0;
  endtask

  initial begin
    exp_t e;
    exp_t g;
    int   s_exp;

    // Each row is one clock cycle; FSM state carries between rows.
    //            rst rs    rt    urs urt br bt rd_ex rw mr rd_mem mm  stall flush
    vecs[0]  = mk(1, 5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 1, 1, 5'd0, 0,  0, 0); // reset forces
    vecs[1]  = mk(0, 5'd8, 5'd0, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0,  1, 0); // load-use
    vecs[2]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0); // stayed RUN
    vecs[3]  = mk(0, 5'd0, 5'd9, 0, 1, 1, 0, 5'd9, 1, 1, 5'd0, 0,  1, 0); // branch after load
    vecs[4]  = mk(0, 5'd0, 5'd9, 0, 1, 1, 0, 5'd9, 1, 1, 5'd0, 0,  1, 0); // HOLD
    vecs[5]  = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0);
    vecs[6]  = mk(0, 5'd0, 5'd0, 1, 0, 0, 0, 5'd0, 1, 1, 5'd0, 0,  0, 0); // r0
    vecs[7]  = mk(0, 5'd0, 5'd5, 0, 0, 0, 0, 5'd5, 1, 1, 5'd0, 0,  0, 0); // rt unused
    vecs[8]  = mk(0, 5'd5, 5'd0, 1, 0, 0, 0, 5'd5, 0, 1, 5'd0, 0,  0, 0); // no RegWrite
    vecs[9]  = mk(0, 5'd0, 5'd0, 0, 0, 1, 1, 5'd0, 0, 0, 5'd0, 0,  0, 1); // taken branch
    vecs[10] = mk(0, 5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 1, 1, 5'd0, 0,  1, 0); // stall beats flush
    vecs[11] = mk(0, 5'd3, 5'd0, 1, 0, 1, 1, 5'd3, 1, 0, 5'd0, 0,  1, 0); // branch on ALU in EX
    vecs[12] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0);
    vecs[13] = mk(0, 5'd0, 5'd4, 0, 1, 1, 0, 5'd0, 0, 0, 5'd4, 1,  1, 0); // branch on MEM load
    vecs[14] = mk(0, 5'd0, 5'd4, 0, 1, 1, 0, 5'd4, 1, 0, 5'd4, 1,  1, 0); // EX and MEM match
    vecs[15] = mk(0, 5'd4, 5'd0, 1, 0, 0, 0, 5'd0, 0, 0, 5'd4, 1,  0, 0); // MEM load, no branch
    vecs[16] = mk(0, 5'd4, 5'd0, 1, 0, 1, 1, 5'd0, 0, 0, 5'd4, 0,  0, 1); // MEM not a load
    vecs[17] = mk(0, 5'd6, 5'd6, 1, 1, 0, 0, 5'd6, 1, 1, 5'd0, 0,  1, 0); // rs==rt, one stall
    vecs[18] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0);
    vecs[19] = mk(0, 5'd7, 5'd0, 1, 0, 1, 1, 5'd7, 1, 1, 5'd0, 0,  1, 0); // need 2
    vecs[20] = mk(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0,  1, 0); // HOLD ignores inputs
    vecs[21] = mk(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0,  0, 1); // flush after stall
    vecs[22] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0);
    vecs[23] = mk(0, 5'd0, 5'd0, 0, 1, 1, 0, 5'd0, 1, 1, 5'd0, 0,  0, 0); // r0 branch operand
    vecs[24] = mk(0, 5'd0, 5'd9, 0, 1, 1, 0, 5'd9, 1, 1, 5'd0, 0,  1, 0); // enter HOLD
    vecs[25] = mk(1, 5'd0, 5'd9, 0, 1, 1, 1, 5'd9, 1, 1, 5'd0, 0,  0, 0); // reset mid-HOLD
    vecs[26] = mk(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 0,  0, 0); // HOLD discarded
    vecs[27] = mk(0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0,  0, 1);

    apply(vecs[0]);
    Reset = 1'b1;
    Reset_s = 1'b1;
    apply_small(5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_s = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i != 0) begin
        @(posedge Clk);
        #1;
      end
      apply(vecs[i]);
      e.idx = i;
      e.pcw = !vecs[i].e_stall;
      e.ifw = !vecs[i].e_stall;
      e.bub = vecs[i].e_stall;
      e.fl  = vecs[i].e_flush;
      e.sc  = m_sc;
      e.fc  = m_fc;
      sb.push_back(e);
      @(negedge Clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard [vec %0d]: got empty queue, expected an entry", i);
      end else begin
        g = sb.pop_front();
        chk("PCWrite",      g.idx, int'(hz.PCWrite),      int'(g.pcw));
        chk("IF_ID_Write",  g.idx, int'(hz.IF_ID_Write),  int'(g.ifw));
        chk("ID_EX_Bubble", g.idx, int'(hz.ID_EX_Bubble), int'(g.bub));
        chk("IF_ID_Flush",  g.idx, int'(hz.IF_ID_Flush),  int'(g.fl));
        chk("StallCount",   g.idx, int'(StallCount),      g.sc);
        chk("FlushCount",   g.idx, int'(FlushCount),      g.fc);
      end
      if (vecs[i].rst) begin
        m_sc = 0;
        m_fc = 0;
      end else begin
        if (vecs[i].e_stall) m_sc++;
        if (vecs[i].e_flush) m_fc++;
      end
    end

    // Saturation on the 4-bit instance: continuous load-use for 22 cycles.
    @(posedge Clk);
    #1;
    apply_small(5'd8, 5'd8, 1'b1);
    for (int i = 0; i < 22; i++) begin
      if (i != 0) begin
        @(posedge Clk);
        #1;
      end
      s_exp = (i < 15) ? i : 15;
      sat_q.push_back(s_exp);
      @(negedge Clk);
      chk("sat ID_EX_Bubble", 100 + i, int'(hzs.ID_EX_Bubble), 1);
      if (sat_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sat scoreboard [step %0d]: got empty queue, expected an entry", i);
      end else begin
        chk("sat StallCount", 100 + i, int'(StallCount_s), sat_q.pop_front());
      end
    end
    @(posedge Clk);
    #1;
    apply_small(5'd0, 5'd0, 1'b0);
    @(negedge Clk);
    chk("sat held StallCount", 200, int'(StallCount_s), 15);
    chk("sat FlushCount",      201, int'(FlushCount_s), 0);
    chk("sat idle PCWrite",    202, int'(hzs.PCWrite),  1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- ID-stage hazard detector; complements ForwardUnit, which covers EX-stage operand hazards.
- Detects dependencies that forwarding cannot cover: load-use, and branch-in-ID operand hazards.
- Drives PC/IF_ID write enables, the ID_EX control bubble and the IF_ID flush.
- Holds a small stall FSM and saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of StallCount and FlushCount

Ports:
Clk  input  1  pipeline clock, all state on rising edge
Reset  input  1  synchronous, active-high
rs_IF_ID  input  5  Instruction[25:21] of instruction in ID
rt_IF_ID  input  5  Instruction[20:16] of instruction in ID
UsesRs_ID  input  1  ID instruction reads rs
UsesRt_ID  input  1  ID instruction reads rt
Branch_ID  input  1  ID instruction is a conditional branch (compares in ID)
BranchTaken_ID  input  1  branch/jump in ID resolves taken (valid only with no hazard)
rd_ID_EX  input  5  destination register of instruction in EX
RegWrite_ID_EX  input  1  EX instruction writes a register
MemRead_ID_EX  input  1  EX instruction is a load
rd_EX_MEM  input  5  destination register of instruction in MEM
MemRead_EX_MEM  input  1  MEM instruction is a load
PCWrite  output  1  PC update enable
IF_ID_Write  output  1  IF_ID register write enable
ID_EX_Bubble  output  1  zero ID_EX control fields this cycle
IF_ID_Flush  output  1  clear IF_ID to NOP this cycle
StallCount  output  CNT_W  saturating count of stall cycles
FlushCount  output  CNT_W  saturating count of flush cycles

Behaviour:
- Match definitions:
  - matchEX = RegWrite_ID_EX && rd_ID_EX!=0 && ((UsesRs_ID && rd_ID_EX==rs_IF_ID) || (UsesRt_ID && rd_ID_EX==rt_IF_ID))
  - matchMEM uses the same form with rd_EX_MEM and MemRead_EX_MEM as the write qualifier.
- Stall need, evaluated combinationally in RUN:
  - need=2: Branch_ID && MemRead_ID_EX && matchEX
  - need=1: MemRead_ID_EX && matchEX && !Branch_ID
  - need=1: Branch_ID && !MemRead_ID_EX && matchEX
  - need=1: Branch_ID && matchMEM && !matchEX
  - need=0: all other cases
- FSM states: RUN, HOLD.
  - RUN, need=0: next state RUN.
  - RUN, need=1: stall this cycle, next state RUN.
  - RUN, need=2: stall this cycle, next state HOLD.
  - HOLD: stall unconditionally, ignore all inputs, next state RUN.
- Stall cycle outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
- Non-stall cycle outputs: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=BranchTaken_ID.
- BranchTaken_ID is ignored in any stall cycle; the flush occurs on the first non-stall cycle in which the branch resolves taken.
- Outputs are combinational from state and inputs; zero-latency detection in the same cycle.
- Register 0 never causes a hazard. rs==rt with both matching counts as one hazard, not two.
- Counters:
  - StallCount increments on every stall cycle, including HOLD.
  - FlushCount increments on every cycle with IF_ID_Flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset, applied in any state, including mid-HOLD:
  - next state RUN; StallCount=0, FlushCount=0.
  - While Reset=1, outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, independent of inputs.
  - A pending HOLD is discarded.
- Simultaneous load-use and taken branch in RUN: the stall wins and the flush is suppressed that cycle.

Decomposition:
- Shared package: FSM state encoding (RUN=1'b0, HOLD=1'b1) and the REG_ZERO=5'd0 constant.
- One natural sub-module: sat_counter (parameter W, inputs Clk, Reset, Inc; output Count); instantiated twice.

Test Plan:
- Load-use: MemRead_ID_EX=1, RegWrite_ID_EX=1, rd_ID_EX=8, rs_IF_ID=8, UsesRs_ID=1, Branch_ID=0 -> one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; state stays RUN; StallCount=1.
- Branch after load: Branch_ID=1, MemRead_ID_EX=1, rd_ID_EX=9=rt_IF_ID, UsesRt_ID=1 -> exactly 2 stall cycles (RUN then HOLD) with inputs held constant; StallCount=2.
- Register 0 and unused operand: rd_ID_EX=0 matching rs=0, or a rt match with UsesRt_ID=0 -> no stall; StallCount stays 0.
- Taken branch: need=0, BranchTaken_ID=1 -> IF_ID_Flush=1 for one cycle with PCWrite=1; FlushCount=1. Load-use plus BranchTaken_ID=1 in the same cycle -> stall, no flush.
- Reset mid-HOLD: enter HOLD, assert Reset -> outputs forced to non-stall values that cycle; next cycle state RUN, both counters 0.
- Saturation: CNT_W=4, force 20 stall cycles -> StallCount=15 and stays at 15.
